// File: rtl/mips_pkg.sv
// mips_pkg: shared state encoding and two's-complement helpers for the mult/div unit.
package mips_pkg;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} md_state_t;
    function automatic logic [DEF_WIDTH-1:0] neg_w(input logic [DEF_WIDTH-1:0] x);
        return ~x + DEF_WIDTH'(1);
    endfunction
    function automatic logic [DEF_WIDTH-1:0] abs_w(input logic [DEF_WIDTH-1:0] x);
        return x[DEF_WIDTH-1] ? neg_w(x) : x;
    endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration followed by an arithmetic right shift of {acc, q, q_-1}.
module booth_step import mips_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);
    // One guard bit on acc keeps acc - m exact when m is the most negative value.
    logic [WIDTH:0] m_ext, sum;
    always_comb begin
        m_ext = {m_i[WIDTH-1], m_i};
        sum = ({q_i[0], q1_i} == 2'b01) ? acc_i + m_ext :
              ({q_i[0], q1_i} == 2'b10) ? acc_i - m_ext : acc_i;
        acc_o = {sum[WIDTH], sum[WIDTH:1]};
        q_o = {sum[0], q_i[WIDTH-1:1]};
        q1_o = q_i[0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) and divide (restoring + sign fix) producing HI/LO.
module mult_div_unit import mips_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divby0flag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0] acc_q, acc_d, bacc, rsh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] q_q, q_d, m_q, m_d, bq, hi_q, hi_d, lo_q, lo_d;
    logic q1_q, q1_d, bq1, sa_q, sa_d, sb_q, sb_d, done_q, done_d, dz_q, dz_d;
    logic go_mult, go_div, last;

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .acc_i(acc_q), .q_i(q_q), .q1_i(q1_q), .m_i(m_q),
        .acc_o(bacc), .q_o(bq), .q1_o(bq1)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            q_q <= '0;
            q1_q <= 1'b0;
            m_q <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            done_q <= 1'b0;
            dz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            q_q <= q_d;
            q1_q <= q1_d;
            m_q <= m_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            done_q <= done_d;
            dz_q <= dz_d;
        end
    end

    always_comb begin
        go_mult = (state_q == IDLE) && start_mult;
        go_div = (state_q == IDLE) && start_div && !start_mult;
        last = cnt_q == CNT_W'(WIDTH-1);
        state_d = state_q;
        case (state_q)
            IDLE: state_d = go_mult ? MULT : (go_div && b != '0) ? DIV : IDLE;
            MULT: state_d = last ? DONE : MULT;
            DIV: state_d = last ? FIX : DIV;
            FIX: state_d = DONE;
            DONE: state_d = done_q ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // DONE spends one cycle writing hi/lo, then holds for the done pulse so no start is accepted during it.
    always_comb begin
        rsh = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff = {1'b0, rsh} - {2'b0, m_q};
        cnt_d = (state_q == MULT || state_q == DIV) ? cnt_q + CNT_W'(1) : '0;
        acc_d = acc_q;
        q_d = q_q;
        q1_d = q1_q;
        m_d = m_q;
        sa_d = sa_q;
        sb_d = sb_q;
        hi_d = hi_q;
        lo_d = lo_q;
        done_d = 1'b0;
        dz_d = go_div && b == '0;
        case (state_q)
            IDLE: begin
                if (go_mult) begin
                    acc_d = '0;
                    q_d = a;
                    q1_d = 1'b0;
                    m_d = b;
                end else if (go_div) begin
                    acc_d = '0;
                    q_d = abs_w(a);
                    m_d = abs_w(b);
                    sa_d = a[WIDTH-1];
                    sb_d = b[WIDTH-1];
                end
            end
            MULT: begin
                acc_d = bacc;
                q_d = bq;
                q1_d = bq1;
            end
            DIV: begin
                acc_d = diff[WIDTH+1] ? rsh : diff[WIDTH:0];
                q_d = {q_q[WIDTH-2:0], !diff[WIDTH+1]};
            end
            FIX: begin
                q_d = (sa_q ^ sb_q) ? neg_w(q_q) : q_q;
                acc_d = {1'b0, sa_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]};
            end
            DONE: begin
                if (!done_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = q_q;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = state_q == MULT || state_q == DIV || state_q == FIX;
        done = done_q;
        divby0flag = dz_q;
        hi = hi_q;
        lo = lo_q;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit with hand-computed HI/LO, latency and handshake checks.
module tb_mult_div_unit;
    logic clk = 1'b0, reset_n = 1'b0, start_mult = 1'b0, start_div = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic busy, done, divby0flag;
    logic [31:0] hi, lo;
    int nvec = 0, nerr = 0;

    mult_div_unit dut (
        .clk(clk), .reset_n(reset_n), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .busy(busy), .done(done), .divby0flag(divby0flag), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic sm, input logic sd, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start_mult = sm;
        start_div = sd;
        a = va;
        b = vb;
        @(negedge clk);
        start_mult = 1'b0;
        start_div = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int lat, output int nbusy, output int nflag);
        lat = 0;
        nbusy = 0;
        nflag = 0;
        while (!done && lat < 100) begin
            nbusy += int'(busy);
            nflag += int'(divby0flag);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic sm, input logic sd, input logic [31:0] va,
                       input logic [31:0] vb, input int elat, input logic [31:0] ehi, input logic [31:0] elo);
        int lat, nb, nf;
        issue(sm, sd, va, vb);
        wait_done(lat, nb, nf);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy cycles"}, 32'(nb), 32'(elat - 1));
        check({tag, " divby0flag"}, 32'(nf), 32'd0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, nb, nf, nd;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset flag", 32'(divby0flag), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset_n = 1'b1;

        run("mul 7*-3", 1'b1, 1'b0, 32'h7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run("mul min*min", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
        run("div -7/2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'h2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div min/-1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000);
        run("div preload", 1'b0, 1'b1, 32'h56781234, 32'h00010000, 34, 32'h1234, 32'h5678);

        issue(1'b0, 1'b1, 32'd5, 32'd0);
        check("div0 flag", 32'(divby0flag), 32'd1);
        check("div0 busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("div0 flag width", 32'(divby0flag), 32'd0);
        nb = 0;
        nd = 0;
        repeat (40) begin
            nb += int'(busy);
            nd += int'(done);
            @(negedge clk);
        end
        check("div0 busy later", 32'(nb), 32'd0);
        check("div0 done", 32'(nd), 32'd0);
        check("div0 hi kept", hi, 32'h1234);
        check("div0 lo kept", lo, 32'h5678);

        issue(1'b1, 1'b0, 32'h1111, 32'h2222);
        repeat (9) @(negedge clk);
        check("abort busy before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        reset_n = 1'b1;
        nd = 0;
        repeat (40) begin
            nd += int'(done);
            @(negedge clk);
        end
        check("abort no done", 32'(nd), 32'd0);
        run("div 9/4", 1'b0, 1'b1, 32'd9, 32'd4, 34, 32'd1, 32'd2);

        run("mul+div 3,4", 1'b1, 1'b1, 32'd3, 32'd4, 33, 32'd0, 32'd12);

        issue(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        start_div = 1'b1;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start_div = 1'b0;
        nd = 0;
        repeat (80) begin
            nd += int'(done);
            @(negedge clk);
        end
        check("busy start dones", 32'(nd), 32'd1);
        check("busy start hi", hi, 32'd0);
        check("busy start lo", lo, 32'd30);

        issue(1'b1, 1'b0, 32'hFFFFFFFE, 32'd3);
        wait_done(lat, nb, nf);
        check("b2b first latency", 32'(lat), 32'd33);
        check("b2b first hi", hi, 32'hFFFFFFFF);
        check("b2b first lo", lo, 32'hFFFFFFFA);
        start_mult = 1'b1;
        a = 32'd2;
        b = 32'd2;
        @(negedge clk);
        check("b2b start in done cycle", 32'(busy), 32'd0);
        @(negedge clk);
        start_mult = 1'b0;
        check("b2b next accepted", 32'(busy), 32'd1);
        wait_done(lat, nb, nf);
        check("b2b second latency", 32'(lat), 32'd33);
        check("b2b second lo", lo, 32'd4);
        check("b2b second hi", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
